branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Execute-stage counterpart of the branch predictor. Carries each fetched instruction's prediction metadata (predicted next PC, prediction flag, GHR snapshot) through a decode/execute shadow pipeline, compares it against the actual outcome computed in Execute, and produces the registered predictor-update bundle plus the flush/redirect pulse to Fetch. Sits between the Execute ALU/comparator and both the predictor update port and the Fetch PC mux.

## Interface

Parameters:
- XLEN, 32, PC/target width
- GHR_W, 4, global history width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- f_valid  in  1  Fetch holds a valid instruction this cycle
- f_pc  in  XLEN  PC of fetched instruction
- f_pred_pc  in  XLEN  predicted next PC from predictor
- f_pred_taken  in  1  predictor's prediction_valid for this fetch
- f_ghr  in  GHR_W  GHR snapshot at fetch
- stall  in  1  hold D and E stages
- ex_is_branch  in  1  E instruction is conditional branch
- ex_is_jump  in  1  E instruction is JAL/JALR
- ex_cond_true  in  1  branch condition evaluated true
- ex_target  in  XLEN  computed target (ALU result)
- branch_resolved  out  1  update strobe to predictor
- branch_taken  out  1  actual direction
- alu_out  out  XLEN  actual target
- resolved_pc  out  XLEN  PC of resolved instruction
- ghr_history  out  GHR_W  GHR snapshot of resolved instruction
- flush  out  1  squash D/E and Fetch capture
- redirect_pc  out  XLEN  correct next PC, valid when flush=1
- perf_branches  out  32  resolved control-transfer count
- perf_mispredicts  out  32  mispredict count

## Operation

- Shadow stages D, E each hold {valid, pc, pred_pc, pred_taken, ghr}.
- Advance (stall=0): D <= F fields with valid = f_valid & ~flush; E <= D.
- stall=1: D, E hold; nothing resolves.
- Resolve when E.valid & ~stall:
  - actual_taken = ex_is_jump | (ex_is_branch & ex_cond_true)
  - actual_next = actual_taken ? ex_target : E.pc + 4 (mod 2^XLEN wrap)
  - mispredict = (E.pred_pc != actual_next); applies to non-branch instructions too (BTB alias with pred_taken=1 redirects to pc+4)
  - update bundle issued only if ex_is_branch | ex_is_jump
- On mispredict, at the clock edge: D.valid <= 0, E.valid <= 0 (overrides shift), flush <= 1, redirect_pc <= actual_next.
- Mispredict of E with stall=0 always wins over normal shift.

## Timing

- All outputs registered; reset value 0 for every output and every stage field.
- Update latency: outputs valid the cycle after the instruction resolves in E; branch_resolved is a one-cycle pulse per instruction, never repeated across stalls.
- flush/redirect: one-cycle pulse, cycle after resolution; during that cycle Fetch input is wrong-path and not captured (D.valid forced 0 if stall=0; if stall=1, D holds its already-cleared state).
- Back-to-back: a correctly predicted branch in E every cycle yields branch_resolved every cycle.
- Reset asserted mid-operation clears stages, pulses, counters immediately (async); first capture on first rising edge after deassertion.

## Configuration

- BRU_PERF_CNT_EN defined: perf_branches increments on each branch_resolved, perf_mispredicts on each flush; 32-bit, wrap 0xFFFFFFFF→0, reset 0.
- Undefined: counters not built; perf_* ports tied to 0.

## Test plan

- Correct taken: f_pc=0x100, f_pred_pc=0x140, BEQ true, ex_target=0x140 -> branch_resolved=1, branch_taken=1, alu_out=0x140, resolved_pc=0x100, flush=0.
- Predicted not-taken, actually taken: f_pc=0x200, f_pred_pc=0x204, cond true, ex_target=0x180 -> flush=1 one cycle, redirect_pc=0x180; next two D/E entries invalid, no update for them.
- Alias: non-branch at 0x300 with f_pred_pc=0x400 -> flush=1, redirect_pc=0x304, branch_resolved=0.
- Stall: branch held in E for 3 stall cycles then released -> exactly one branch_resolved pulse, ghr_history equals f_ghr captured (e.g. 4'b1011).
- Wrap: f_pc=0xFFFFFFFC not-taken, f_pred_pc=0x0 -> no flush.
- With BRU_PERF_CNT_EN: 5 branches, 2 mispredicts -> perf_branches=5, perf_mispredicts=2; rst low mid-run -> both 0 and all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit : shadow D/E pipeline for prediction metadata, resolves
// predictions in Execute and emits predictor update, flush and redirect.
// Optional: define BRU_PERF_CNT_EN to build the performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int GHR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic [XLEN-1:0]  f_pc,
  input  logic [XLEN-1:0]  f_pred_pc,
  input  logic             f_pred_taken,
  input  logic [GHR_W-1:0] f_ghr,
  input  logic             stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_cond_true,
  input  logic [XLEN-1:0]  ex_target,
  output logic             branch_resolved,
  output logic             branch_taken,
  output logic [XLEN-1:0]  alu_out,
  output logic [XLEN-1:0]  resolved_pc,
  output logic [GHR_W-1:0] ghr_history,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispredicts
);

  logic             d_valid, e_valid;
  logic [XLEN-1:0]  d_pc, e_pc, d_pred_pc, e_pred_pc;
  logic             d_pred_taken, e_pred_taken;
  logic [GHR_W-1:0] d_ghr, e_ghr;

  logic             resolve;
  logic             is_ctrl;
  logic             actual_taken;
  logic [XLEN-1:0]  actual_next;
  logic             mispredict;

  // Mispredict is judged on the predicted next PC alone; the direction flag
  // travels with the instruction but does not affect the comparison.
  logic unused_pred_taken;
  assign unused_pred_taken = e_pred_taken;

  assign resolve      = e_valid & ~stall;
  assign is_ctrl      = ex_is_branch | ex_is_jump;
  assign actual_taken = ex_is_jump | (ex_is_branch & ex_cond_true);
  assign actual_next  = actual_taken ? ex_target : (e_pc + XLEN'(4));
  assign mispredict   = resolve & (e_pred_pc != actual_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid         <= 1'b0;
      d_pc            <= '0;
      d_pred_pc       <= '0;
      d_pred_taken    <= 1'b0;
      d_ghr           <= '0;
      e_valid         <= 1'b0;
      e_pc            <= '0;
      e_pred_pc       <= '0;
      e_pred_taken    <= 1'b0;
      e_ghr           <= '0;
      branch_resolved <= 1'b0;
      branch_taken    <= 1'b0;
      alu_out         <= '0;
      resolved_pc     <= '0;
      ghr_history     <= '0;
      flush           <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      if (!stall) begin
        // Fetch input during the flush pulse is wrong-path and never captured.
        d_valid      <= f_valid & ~flush & ~mispredict;
        d_pc         <= f_pc;
        d_pred_pc    <= f_pred_pc;
        d_pred_taken <= f_pred_taken;
        d_ghr        <= f_ghr;
        e_valid      <= d_valid & ~mispredict;
        e_pc         <= d_pc;
        e_pred_pc    <= d_pred_pc;
        e_pred_taken <= d_pred_taken;
        e_ghr        <= d_ghr;
      end

      branch_resolved <= resolve & is_ctrl;
      if (resolve && is_ctrl) begin
        branch_taken <= actual_taken;
        alu_out      <= ex_target;
        resolved_pc  <= e_pc;
        ghr_history  <= e_ghr;
      end

      flush <= mispredict;
      if (mispredict) begin
        redirect_pc <= actual_next;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (branch_resolved) perf_branches <= perf_branches + 32'd1;
      if (flush)           perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// tb_branch_resolve_unit : directed self-checking bench for branch_resolve_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc, f_pred_pc;
  logic        f_pred_taken;
  logic [3:0]  f_ghr;
  logic        stall;
  logic        ex_is_branch, ex_is_jump, ex_cond_true;
  logic [31:0] ex_target;
  logic        branch_resolved, branch_taken, flush;
  logic [31:0] alu_out, resolved_pc, redirect_pc;
  logic [3:0]  ghr_history;
  logic [31:0] perf_branches, perf_mispredicts;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_br, exp_mp;

  branch_resolve_unit #(.XLEN(32), .GHR_W(4)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_pc(f_pc), .f_pred_pc(f_pred_pc),
    .f_pred_taken(f_pred_taken), .f_ghr(f_ghr),
    .stall(stall),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_cond_true(ex_cond_true), .ex_target(ex_target),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .alu_out(alu_out), .resolved_pc(resolved_pc), .ghr_history(ghr_history),
    .flush(flush), .redirect_pc(redirect_pc),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Fetch one instruction, let it reach E, then present its outcome for one cycle.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] pred, input logic [3:0] ghr,
                           input logic br, input logic jmp, input logic cond,
                           input logic [31:0] tgt);
    f_valid = 1'b1; f_pc = pc; f_pred_pc = pred; f_ghr = ghr; f_pred_taken = (pred != pc + 32'd4);
    tick();
    f_valid = 1'b0;
    tick();
    ex_is_branch = br; ex_is_jump = jmp; ex_cond_true = cond; ex_target = tgt;
    tick();
    ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_cond_true = 1'b0; ex_target = '0;
  endtask

  initial begin
    rst = 1'b0; f_valid = 1'b0; f_pc = '0; f_pred_pc = '0; f_pred_taken = 1'b0; f_ghr = '0;
    stall = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_cond_true = 1'b0; ex_target = '0;
`ifdef BRU_PERF_CNT_EN
    exp_br = 32'd5; exp_mp = 32'd3;
`else
    exp_br = 32'd0; exp_mp = 32'd0;
`endif

    repeat (3) tick();
    chk("rst_resolved", {31'b0, branch_resolved}, 32'd0);
    chk("rst_taken",    {31'b0, branch_taken},    32'd0);
    chk("rst_alu_out",  alu_out,                  32'd0);
    chk("rst_res_pc",   resolved_pc,              32'd0);
    chk("rst_ghr",      {28'b0, ghr_history},     32'd0);
    chk("rst_flush",    {31'b0, flush},           32'd0);
    chk("rst_redirect", redirect_pc,              32'd0);
    rst = 1'b1;
    tick();

    // Correctly predicted taken BEQ
    run_instr(32'h100, 32'h140, 4'b0110, 1'b1, 1'b0, 1'b1, 32'h140);
    chk("ok_resolved", {31'b0, branch_resolved}, 32'd1);
    chk("ok_taken",    {31'b0, branch_taken},    32'd1);
    chk("ok_alu_out",  alu_out,                  32'h140);
    chk("ok_res_pc",   resolved_pc,              32'h100);
    chk("ok_ghr",      {28'b0, ghr_history},     32'h6);
    chk("ok_flush",    {31'b0, flush},           32'd0);
    tick();
    chk("ok_pulse_end", {31'b0, branch_resolved}, 32'd0);

    // Predicted not-taken, actually taken, with two younger valid fetches behind it
    f_valid = 1'b1; f_pc = 32'h200; f_pred_pc = 32'h204; f_ghr = 4'h0; f_pred_taken = 1'b0;
    tick();
    f_pc = 32'h204; f_pred_pc = 32'h208;
    tick();
    f_pc = 32'h208; f_pred_pc = 32'h20c;
    ex_is_branch = 1'b1; ex_cond_true = 1'b1; ex_target = 32'h180;
    tick();
    chk("mp_flush",    {31'b0, flush},           32'd1);
    chk("mp_redirect", redirect_pc,              32'h180);
    chk("mp_resolved", {31'b0, branch_resolved}, 32'd1);
    chk("mp_res_pc",   resolved_pc,              32'h200);
    f_pc = 32'h300; f_pred_pc = 32'h304; ex_target = 32'h999;
    tick();
    chk("mp_sq1_resolved", {31'b0, branch_resolved}, 32'd0);
    chk("mp_sq1_flush",    {31'b0, flush},           32'd0);
    f_valid = 1'b0;
    tick();
    chk("mp_sq2_resolved", {31'b0, branch_resolved}, 32'd0);
    chk("mp_sq2_flush",    {31'b0, flush},           32'd0);
    ex_is_branch = 1'b0; ex_cond_true = 1'b0; ex_target = '0;
    tick();

    // BTB alias on a non-branch
    run_instr(32'h300, 32'h400, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("alias_flush",    {31'b0, flush},           32'd1);
    chk("alias_redirect", redirect_pc,              32'h304);
    chk("alias_resolved", {31'b0, branch_resolved}, 32'd0);
    tick();

    // Branch held in E by three stall cycles
    f_valid = 1'b1; f_pc = 32'h500; f_pred_pc = 32'h504; f_ghr = 4'b1011; f_pred_taken = 1'b0;
    tick();
    f_valid = 1'b0; f_ghr = 4'h0;
    tick();
    ex_is_branch = 1'b1; ex_cond_true = 1'b0; ex_target = 32'h5a0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_resolve", {31'b0, branch_resolved}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("stall_resolved", {31'b0, branch_resolved}, 32'd1);
    chk("stall_ghr",      {28'b0, ghr_history},     32'hb);
    chk("stall_res_pc",   resolved_pc,              32'h500);
    chk("stall_taken",    {31'b0, branch_taken},    32'd0);
    chk("stall_alu_out",  alu_out,                  32'h5a0);
    chk("stall_flush",    {31'b0, flush},           32'd0);
    ex_is_branch = 1'b0; ex_target = '0;
    tick();
    chk("stall_once", {31'b0, branch_resolved}, 32'd0);

    // Not-taken branch at the top of the address space: pc+4 wraps to 0
    run_instr(32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h80);
    chk("wrap_flush",    {31'b0, flush},           32'd0);
    chk("wrap_resolved", {31'b0, branch_resolved}, 32'd1);
    chk("wrap_res_pc",   resolved_pc,              32'hFFFF_FFFC);

    // Unpredicted JAL
    run_instr(32'h600, 32'h604, 4'h0, 1'b0, 1'b1, 1'b0, 32'h700);
    chk("jal_flush",    {31'b0, flush},        32'd1);
    chk("jal_redirect", redirect_pc,           32'h700);
    chk("jal_taken",    {31'b0, branch_taken}, 32'd1);
    tick();
    chk("perf_branches",    perf_branches,    exp_br);
    chk("perf_mispredicts", perf_mispredicts, exp_mp);

    // Asynchronous reset mid-cycle clears everything without a clock edge
    run_instr(32'h700, 32'h720, 4'h5, 1'b0, 1'b1, 1'b0, 32'h740);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_flush",    {31'b0, flush},           32'd0);
    chk("arst_redirect", redirect_pc,              32'd0);
    chk("arst_resolved", {31'b0, branch_resolved}, 32'd0);
    chk("arst_res_pc",   resolved_pc,              32'd0);
    chk("arst_alu_out",  alu_out,                  32'd0);
    chk("arst_ghr",      {28'b0, ghr_history},     32'd0);
    chk("arst_perf_b",   perf_branches,            32'd0);
    chk("arst_perf_m",   perf_mispredicts,         32'd0);
    #1;
    rst = 1'b1;

    run_instr(32'h800, 32'h804, 4'h3, 1'b1, 1'b0, 1'b0, 32'h900);
    chk("post_rst_resolved", {31'b0, branch_resolved}, 32'd1);
    chk("post_rst_res_pc",   resolved_pc,              32'h800);
    chk("post_rst_flush",    {31'b0, flush},           32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
